k86_sram_bridge: RTL and testbench
==================================

Name: k86_sram_bridge

Overview:
- Downstream memory stage for the K8088 core. It converts the core's byte bus into cycles on a 16-bit asynchronous external SRAM.
- The core's address, out and we are treated as one memory request per core step. The bridge executes that request with programmable wait states.
- When the read data on cpu_in is valid, or the write has completed, the bridge pulses the core's ce for one clock.
- It replaces the behavioural byte memory used in simulation, so the core runs unchanged on board SRAM.

Parameters:
- SRAM_AW, 18: SRAM word-address width. Core byte space is 2^(SRAM_AW+1) bytes; core address bits above SRAM_AW are ignored, so the reset vector FFFF0 aliases to the top of SRAM.
- WAIT, 1: extra access clocks (0..15) for SRAM tAA/tWP.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_address  in  20  core byte address
- cpu_out  in  8  core write data
- cpu_we  in  1  core write request
- cpu_in  out  8  read data to core; held until next read completes
- cpu_ce  out  1  one-clock pulse; the core advances one step on it
- sram_addr  out  SRAM_AW  word address = cpu_address[SRAM_AW:1]
- sram_dq_o  out  16  write data; cpu_out replicated on both bytes
- sram_dq_i  in  16  read data from pads
- sram_dq_oe  out  1  pad output enable (1 = drive)
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active-low
- sram_ub_n, sram_lb_n  out  1  byte lanes; address bit 0 = 1 selects UB, 0 selects LB

Behaviour:
- Reset (asynchronous, immediate):
  - state = S_ISSUE, cpu_ce = 0, cpu_in = 8'hFF.
  - All SRAM strobes = 1, sram_dq_oe = 0, sram_addr = 0, wait counter = 0.
  - Reset asserted mid-access aborts the access. No write pulse is truncated into a glitch: we_n returns high on the same asynchronous edge.
- S_ISSUE (1 clock):
  - Register the request fields: address, we, out.
  - Drive sram_addr and ce_n = 0. Assert the selected lane's ub_n/lb_n; the other lane stays 1.
  - Read: oe_n = 0, dq_oe = 0.
  - Write: oe_n = 1, dq_oe = 1, we_n = 1.
  - Load counter = WAIT, then go to S_WAIT.
- S_WAIT (WAIT+1 clocks):
  - Write: we_n = 0 for the whole state.
  - Counter decrements each clock. When counter = 0:
    - Read: capture the selected lane of sram_dq_i into cpu_in.
    - Write: we_n returns to 1 on exit.
  - Then go to S_DONE.
- S_DONE (1 clock):
  - ce_n/oe_n/lanes = 1. dq_oe stays 1 for this clock after a write (data hold), then drops to 0.
  - cpu_ce = 1 for exactly this clock, then go to S_ISSUE.
- Core step cost: WAIT+3 clocks. With WAIT=1, cpu_ce has period 4.
- The core must hold address/out/we stable from S_ISSUE until it sees cpu_ce. The bridge samples only in S_ISSUE, so changes at any other time are ignored.
- cpu_in is unchanged by writes.
- Address aliasing: for example 20'hFFFF0 with SRAM_AW=18 gives sram_addr = 18'h3FFF8 with LB selected.

Optional Feature:
- MEM_BRIDGE_CACHE_EN enables a one-entry word read cache.
- With the macro defined:
  - Cache state: a 16-bit data register, a tag (word address) and a valid bit; reset clears valid.
  - A read whose word address matches a valid tag goes S_ISSUE → S_DONE with no SRAM strobes asserted. cpu_in takes the cached lane. Cost is 2 clocks.
  - A read miss fills the whole word and sets valid.
  - A write to the tagged word updates the cached byte; a write to any other word leaves the cache untouched.
- Without the macro, every request performs a full SRAM access.

Decomposition:
- Shared package k86_pkg:
  - state enum {S_ISSUE, S_WAIT, S_DONE}
  - WAIT counter width constant (4)
  - lane-select helper function (address bit 0 → {ub_n, lb_n})
- No sub-module needed. The cache is small enough to stay inline under the macro.

Test Plan:
- Reset, then hold reset low, SRAM model preloaded with word 3FFF8 = 16'h00EA, WAIT=1 → cpu_ce pulses every 4 clocks; first read of FFFF0 gives cpu_in = 8'hEA, lb_n = 0, ub_n = 1.
- Write cpu_address=00011, cpu_out=5A → we_n low for exactly 2 clocks, ub_n = 0, dq_o = 5A5A; a subsequent read of 00011 returns 5A and word 0008 low byte is unchanged.
- WAIT=0 and WAIT=15 → cpu_ce period 3 and 18 respectively; oe_n low for 1 and 16 clocks.
- Assert reset during S_WAIT of a write → we_n, ce_n, dq_oe deassert within the same timestep; cpu_ce stays 0; cpu_in = FF; the SRAM word is either old or new, never partial.
- With MEM_BRIDGE_CACHE_EN:
  - Read 00020 then 00021 → second read gives cpu_ce 2 clocks after the first cpu_ce with no ce_n activity.
  - Write 00021 = 77, then read 00021 → hit returning 77.
  - Write 00040, then read 00020 → still a hit.
- Without MEM_BRIDGE_CACHE_EN, the same sequence → every read asserts ce_n and costs WAIT+3 clocks.

Source files
------------

// File: rtl/k86_pkg.sv
// Shared types and helpers for the K8088 SRAM bridge.
package k86_pkg;

   typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam int CNT_W = 4;

   // Address bit 0 picks the byte lane; returns {ub_n, lb_n}.
   function automatic logic [1:0] lane_sel(input logic a0);
      return a0 ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic a0);
      return a0 ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/k86_sram_bridge.sv
// Byte-bus to 16-bit async SRAM bridge with programmable wait states.
// Define MEM_BRIDGE_CACHE_EN to add a one-entry word read cache.
module k86_sram_bridge
   import k86_pkg::*;
#(
   parameter int SRAM_AW = 18,
   parameter int WAIT    = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [19:0]        cpu_address,
   input  logic [7:0]         cpu_out,
   input  logic               cpu_we,
   output logic [7:0]         cpu_in,
   output logic               cpu_ce,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_o,
   input  logic [15:0]        sram_dq_i,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               r_we;
   logic               r_a0;
   logic [SRAM_AW-1:0] word_a;

   // Core address bits above the SRAM window simply alias.
   logic unused_hi;
   assign unused_hi = ^cpu_address[19:SRAM_AW+1];
   assign word_a    = cpu_address[SRAM_AW:1];

`ifdef MEM_BRIDGE_CACHE_EN
   logic [15:0]        c_data;
   logic [SRAM_AW-1:0] c_tag;
   logic               c_valid;
   logic               c_hit;
   assign c_hit = !cpu_we && c_valid && (c_tag == word_a);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_ISSUE;
         cnt        <= '0;
         r_we       <= 1'b0;
         r_a0       <= 1'b0;
         cpu_ce     <= 1'b0;
         cpu_in     <= 8'hFF;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_ub_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
`ifdef MEM_BRIDGE_CACHE_EN
         c_data     <= '0;
         c_tag      <= '0;
         c_valid    <= 1'b0;
`endif
      end else begin
         case (state)
            S_ISSUE: begin
               r_we      <= cpu_we;
               r_a0      <= cpu_address[0];
               sram_addr <= word_a;
               sram_dq_o <= {2{cpu_out}};
               cnt       <= CNT_W'(WAIT);
`ifdef MEM_BRIDGE_CACHE_EN
               if (c_hit) begin
                  cpu_in <= pick_byte(c_data, cpu_address[0]);
                  cpu_ce <= 1'b1;
                  state  <= S_DONE;
               end else
`endif
               begin
                  // Strobes go active as the access enters S_WAIT; a write
                  // holds we_n low for every S_WAIT clock.
                  sram_ce_n              <= 1'b0;
                  {sram_ub_n, sram_lb_n} <= lane_sel(cpu_address[0]);
                  sram_oe_n              <= cpu_we;
                  sram_we_n              <= !cpu_we;
                  sram_dq_oe             <= cpu_we;
                  state                  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  sram_ub_n <= 1'b1;
                  sram_lb_n <= 1'b1;
                  if (!r_we)
                     cpu_in <= pick_byte(sram_dq_i, r_a0);
`ifdef MEM_BRIDGE_CACHE_EN
                  if (!r_we) begin
                     c_data  <= sram_dq_i;
                     c_tag   <= sram_addr;
                     c_valid <= 1'b1;
                  end else if (c_valid && c_tag == sram_addr) begin
                     if (r_a0) c_data[15:8] <= sram_dq_o[7:0];
                     else      c_data[7:0]  <= sram_dq_o[7:0];
                  end
`endif
                  cpu_ce <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               // dq_oe was left high through this clock to hold write data.
               cpu_ce     <= 1'b0;
               sram_dq_oe <= 1'b0;
               state      <= S_ISSUE;
            end
            default: state <= S_ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_k86_sram_bridge.sv
// Directed bench for k86_sram_bridge: WAIT=1 main instance with SRAM model,
// WAIT=0 and WAIT=15 instances for timing.
module tb_k86_sram_bridge;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;

   logic [7:0]  cpu_in;
   logic        cpu_ce;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   logic [7:0]  in0, in15;
   logic        ce0, ce15, dqoe0, dqoe15, cen0, cen15, oen0, oen15;
   logic        wen0, wen15, ubn0, ubn15, lbn0, lbn15;
   logic [17:0] a0, a15;
   logic [15:0] dqo0, dqo15;

   k86_sram_bridge #(.SRAM_AW(18), .WAIT(1)) u1 (
      .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_ce(cpu_ce), .sram_addr(sram_addr),
      .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n));

   k86_sram_bridge #(.SRAM_AW(18), .WAIT(0)) u0 (
      .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(in0), .cpu_ce(ce0), .sram_addr(a0),
      .sram_dq_o(dqo0), .sram_dq_i(16'h1234), .sram_dq_oe(dqoe0),
      .sram_ce_n(cen0), .sram_oe_n(oen0), .sram_we_n(wen0),
      .sram_ub_n(ubn0), .sram_lb_n(lbn0));

   k86_sram_bridge #(.SRAM_AW(18), .WAIT(15)) u15 (
      .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(in15), .cpu_ce(ce15), .sram_addr(a15),
      .sram_dq_o(dqo15), .sram_dq_i(16'h1234), .sram_dq_oe(dqoe15),
      .sram_ce_n(cen15), .sram_oe_n(oen15), .sram_we_n(wen15),
      .sram_ub_n(ubn15), .sram_lb_n(lbn15));

`ifdef MEM_BRIDGE_CACHE_EN
   localparam int HIT_CLKS = 2;
   localparam int HIT_CE   = 0;
`else
   localparam int HIT_CLKS = 4;
   localparam int HIT_CE   = 2;
`endif

   // SRAM model: word array, byte-lane writes while ce_n and we_n are low.
   logic [15:0] mem [logic [17:0]];
   logic [15:0] mw;

   function automatic logic [15:0] rd(input logic [17:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   always @(posedge clock) begin
      if (!sram_ce_n && !sram_we_n) begin
         mw = rd(sram_addr);
         if (!sram_ub_n) mw[15:8] = sram_dq_o[15:8];
         if (!sram_lb_n) mw[7:0]  = sram_dq_o[7:0];
         mem[sram_addr] = mw;
      end
   end

   always @(negedge clock)
      sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? rd(sram_addr) : 16'hFFFF;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   int          clks, oe_lo, we_lo, ce_lo;
   logic        ub, lb;
   logic [15:0] dqo;

   // One core step on u1; returns at the negedge where cpu_ce is seen.
   task automatic step(input logic [19:0] a, input logic we, input logic [7:0] d);
      cpu_address = a; cpu_we = we; cpu_out = d;
      clks = 0; oe_lo = 0; we_lo = 0; ce_lo = 0; ub = 1'b1; lb = 1'b1; dqo = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         clks++;
         if (!sram_oe_n) oe_lo++;
         if (!sram_we_n) we_lo++;
         if (!sram_ce_n) begin
            ce_lo++; ub = sram_ub_n; lb = sram_lb_n; dqo = sram_dq_o;
         end
         if (cpu_ce) break;
      end
      if (!cpu_ce) chk("step_timeout", {31'd0, cpu_ce}, 32'd1);
   endtask

   // Period and oe_n-low count between two cpu_ce pulses of u0 (sel=0) or u15.
   task automatic meas(input bit sel, output int per, output int oel);
      int k;
      per = 0; oel = 0; k = 0;
      while (!(sel ? ce15 : ce0) && k < 100) begin @(negedge clock); k++; end
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         per++;
         if (!(sel ? oen15 : oen0)) oel++;
         if (sel ? ce15 : ce0) break;
      end
      if (!(sel ? ce15 : ce0)) chk("meas_timeout", {31'd0, (sel ? ce15 : ce0)}, 32'd1);
   endtask

   int  per, oel;
   logic [15:0] w;

   initial begin
      mem[18'h3FFF8] = 16'h00EA;
      mem[18'h00008] = 16'h00C3;
      mem[18'h00010] = 16'hBBAA;
      mem[18'h00040] = 16'h1111;
      cpu_address = 20'hFFFF0; cpu_we = 1'b0; cpu_out = 8'h00;
      repeat (2) @(negedge clock);

      chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
      chk("rst_cpu_in", {24'd0, cpu_in}, 32'hFF);
      chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
      chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);

      reset = 1'b0;
      step(20'hFFFF0, 1'b0, 8'h00);
      chk("rd_vec_data", {24'd0, cpu_in}, 32'hEA);
      chk("rd_vec_lanes", {30'd0, ub, lb}, 32'b10);
      step(20'hFFFF0, 1'b0, 8'h00);
      chk("period_w1", clks, 32'd4);
      chk("oe_lo_w1", oe_lo, 32'd2);

      step(20'h00011, 1'b1, 8'h5A);
      chk("wr_we_lo", we_lo, 32'd2);
      chk("wr_lanes", {30'd0, ub, lb}, 32'b01);
      chk("wr_dq_o", {16'd0, dqo}, 32'h5A5A);
      chk("wr_keeps_in", {24'd0, cpu_in}, 32'hEA);
      chk("wr_mem", {16'd0, rd(18'h00008)}, 32'h5AC3);
      step(20'h00011, 1'b0, 8'h00);
      chk("rd_ub", {24'd0, cpu_in}, 32'h5A);
      step(20'h00010, 1'b0, 8'h00);
      chk("rd_lb", {24'd0, cpu_in}, 32'hC3);

      meas(1'b0, per, oel);
      chk("period_w0", per, 32'd3);
      chk("oe_lo_w0", oel, 32'd1);
      meas(1'b1, per, oel);
      chk("period_w15", per, 32'd18);
      chk("oe_lo_w15", oel, 32'd16);

      // u1 is parked at the negedge of its cpu_ce after meas? Resync first.
      step(20'h00010, 1'b0, 8'h00);

      step(20'h00020, 1'b0, 8'h00);
      chk("c_miss_data", {24'd0, cpu_in}, 32'hAA);
      step(20'h00021, 1'b0, 8'h00);
      chk("c_hit_data", {24'd0, cpu_in}, 32'hBB);
      chk("c_hit_clks", clks, HIT_CLKS);
      chk("c_hit_ce", ce_lo, HIT_CE);
      step(20'h00021, 1'b1, 8'h77);
      step(20'h00021, 1'b0, 8'h00);
      chk("c_wr_hit_data", {24'd0, cpu_in}, 32'h77);
      chk("c_wr_hit_clks", clks, HIT_CLKS);
      step(20'h00040, 1'b1, 8'h12);
      step(20'h00020, 1'b0, 8'h00);
      chk("c_other_wr_data", {24'd0, cpu_in}, 32'hAA);
      chk("c_other_wr_clks", clks, HIT_CLKS);
      chk("c_other_wr_ce", ce_lo, HIT_CE);

      // Reset in the middle of a write.
      cpu_address = 20'h00081; cpu_we = 1'b1; cpu_out = 8'h33;
      for (int i = 0; i < 10 && sram_we_n; i++) @(negedge clock);
      chk("rw_we_seen", {31'd0, sram_we_n}, 32'd0);
      reset = 1'b1;
      #1;
      chk("rw_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rw_ce_n", {31'd0, sram_ce_n}, 32'd1);
      chk("rw_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rw_cpu_ce", {31'd0, cpu_ce}, 32'd0);
      chk("rw_cpu_in", {24'd0, cpu_in}, 32'hFF);
      w = rd(18'h00040);
      chk("rw_word_whole", {31'd0, (w == 16'h1111 || w == 16'h3311)}, 32'd1);
      repeat (2) @(negedge clock);
      chk("rw_word_after", {16'd0, rd(18'h00040)}, {16'd0, w});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
